// File: rtl/clock_set_pkg.sv
// Shared types and helpers for the clock time-setting front end.
// Contents:
//   state_e      - set FSM states (IDLE, SET_HOUR, SET_MIN, COMMIT)
//   HOUR_MAX_24, HOUR_MAX_12, MIN_MAX - highest legal value of each field
//   bcd_value    - two-digit BCD pair to binary
//   bcd_in_range - both digits decimal and value <= max
//   bcd_inc      - increment a BCD pair, wrapping to 00 past max
package clock_set_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } state_e;

  localparam logic [6:0] HOUR_MAX_24 = 7'd23;
  localparam logic [6:0] HOUR_MAX_12 = 7'd11;
  localparam logic [6:0] MIN_MAX     = 7'd59;

  function automatic logic [7:0] bcd_value(input logic [3:0] ones, input logic [3:0] tens);
    return ({4'b0000, tens} * 8'd10) + {4'b0000, ones};
  endfunction

  function automatic logic bcd_in_range(input logic [3:0] ones, input logic [3:0] tens,
                                        input logic [6:0] max_val);
    return (ones <= 4'd9) && (tens <= 4'd9) && (bcd_value(ones, tens) <= {1'b0, max_val});
  endfunction

  // Returns {tens, ones}. A pair already at or beyond max (e.g. the hour
  // range shrank mid-edit) or holding a non-decimal digit restarts at 00.
  function automatic logic [7:0] bcd_inc(input logic [3:0] ones, input logic [3:0] tens,
                                         input logic [6:0] max_val);
    logic [7:0] res;
    if (!bcd_in_range(ones, tens, max_val) || (bcd_value(ones, tens) == {1'b0, max_val})) begin
      res = 8'h00;
    end else if (ones == 4'd9) begin
      res = {tens + 4'd1, 4'd0};
    end else begin
      res = {tens, ones + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser + debouncer for one active-low push key.
// Ports:
//   pCLK    in  system clock
//   nRST    in  asynchronous active-low reset
//   tick_i  in  sample strobe (one pCLK cycle wide)
//   key_i   in  raw key, 0 = pressed, asynchronous to pCLK
//   level_o out debounced key level (1 = released)
//   press_o out one-cycle pulse on a debounced 1->0 transition
module key_debounce #(
  parameter int DEB_CNT = 16
) (
  input  logic pCLK,
  input  logic nRST,
  input  logic tick_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEB_CNT + 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the run.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick_i) begin
      if (sync2_q != level_q) begin
        if (cnt_q == CW'(DEB_CNT - 1)) begin
          level_d = sync2_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge pCLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= level_q & ~level_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/clock_time_setter.sv
// Time-entry front end: debounced MODE/INC keys drive an hour/minute set
// FSM, hand the edited BCD time to the clock with a one-cycle load strobe,
// and blink the field being edited via a per-digit blank mask.
// Ports:
//   pCLK, nRST              clock, asynchronous active-low reset
//   KEY_MODE, KEY_INC       raw active-low keys
//   mode_24h                1 = 00..23, 0 = 00..11
//   cur_h/m_tens/ones       live BCD time from the clock
//   set_h/m_tens/ones       edited BCD time
//   load                    one-cycle strobe to the clock counters
//   setting                 high in SET_HOUR / SET_MIN
//   blank                   bit3 = h_tens .. bit0 = m_ones, 1 = blank
module clock_time_setter
  import clock_set_pkg::*;
#(
  parameter int DEB_DIV       = 8000,
  parameter int DEB_CNT       = 16,
  parameter int REP_DELAY     = 500,
  parameter int REP_RATE      = 100,
  parameter int BLINK_TICKS   = 250,
  parameter int TIMEOUT_TICKS = 10000
) (
  input  logic       pCLK,
  input  logic       nRST,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  input  logic       mode_24h,
  input  logic [3:0] cur_h_tens,
  input  logic [3:0] cur_h_ones,
  input  logic [3:0] cur_m_tens,
  input  logic [3:0] cur_m_ones,
  output logic [3:0] set_h_tens,
  output logic [3:0] set_h_ones,
  output logic [3:0] set_m_tens,
  output logic [3:0] set_m_ones,
  output logic       load,
  output logic       setting,
  output logic [3:0] blank
);

  localparam int PW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam int RW = $clog2(REP_DELAY + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  // Prescaler and sample tick
  logic [PW-1:0] pre_q;
  logic          tick_q;

  // Keys
  logic mode_level_unused, mode_press, inc_level, inc_press;

  key_debounce #(.DEB_CNT(DEB_CNT)) u_mode (
    .pCLK(pCLK), .nRST(nRST), .tick_i(tick_q), .key_i(KEY_MODE),
    .level_o(mode_level_unused), .press_o(mode_press)
  );

  key_debounce #(.DEB_CNT(DEB_CNT)) u_inc (
    .pCLK(pCLK), .nRST(nRST), .tick_i(tick_q), .key_i(KEY_INC),
    .level_o(inc_level), .press_o(inc_press)
  );

  // Auto-repeat: after the first repeat the counter is rewound so the next
  // one lands REP_RATE ticks later.
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_fire, rep_q;

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_fire  = 1'b0;
    if (inc_level) begin
      rep_cnt_d = '0;
    end else if (tick_q) begin
      if (rep_cnt_q == RW'(REP_DELAY - 1)) begin
        rep_fire  = 1'b1;
        rep_cnt_d = RW'(REP_DELAY - REP_RATE);
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pCLK or negedge nRST) begin
    if (!nRST) begin
      pre_q     <= '0;
      tick_q    <= 1'b0;
      rep_cnt_q <= '0;
      rep_q     <= 1'b0;
    end else begin
      tick_q    <= (pre_q == PW'(DEB_DIV - 1));
      pre_q     <= (pre_q == PW'(DEB_DIV - 1)) ? '0 : pre_q + 1'b1;
      rep_cnt_q <= rep_cnt_d;
      rep_q     <= rep_fire;
    end
  end

  // Events: MODE wins over a coincident INC
  logic mode_ev, inc_ev, any_ev;
  assign mode_ev = mode_press;
  assign inc_ev  = (inc_press | rep_q) & ~mode_press;
  assign any_ev  = mode_press | inc_press | rep_q;

  // FSM and datapath registers
  state_e        state_q, state_d;
  logic [3:0]    ht_q, ho_q, mt_q, mo_q, ht_d, ho_d, mt_d, mo_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic          load_q, load_d, setting_q, setting_d;
  logic [3:0]    blank_q, blank_d;

  logic       in_set, next_set, tmo_expire;
  logic [6:0] hour_max;

  assign in_set     = (state_q == SET_HOUR) || (state_q == SET_MIN);
  assign next_set   = (state_d == SET_HOUR) || (state_d == SET_MIN);
  assign tmo_expire = in_set && tick_q && !any_ev && (tmo_q == TW'(TIMEOUT_TICKS - 1));
  assign hour_max   = mode_24h ? HOUR_MAX_24 : HOUR_MAX_12;

  // State register
  always_ff @(posedge pCLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      ht_q      <= '0;
      ho_q      <= '0;
      mt_q      <= '0;
      mo_q      <= '0;
      tmo_q     <= '0;
      blink_q   <= '0;
      phase_q   <= 1'b0;
      load_q    <= 1'b0;
      setting_q <= 1'b0;
      blank_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      ht_q      <= ht_d;
      ho_q      <= ho_d;
      mt_q      <= mt_d;
      mo_q      <= mo_d;
      tmo_q     <= tmo_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      load_q    <= load_d;
      setting_q <= setting_d;
      blank_q   <= blank_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (mode_ev) state_d = SET_HOUR;
      SET_HOUR: if (mode_ev) state_d = SET_MIN;  else if (tmo_expire) state_d = IDLE;
      SET_MIN:  if (mode_ev) state_d = COMMIT;   else if (tmo_expire) state_d = IDLE;
      COMMIT:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs and datapath; outputs are computed from state_d so the
  // registered copies line up with state_q.
  always_comb begin
    ht_d = ht_q;
    ho_d = ho_q;
    mt_d = mt_q;
    mo_d = mo_q;
    if ((state_q == IDLE) && mode_ev) begin
      mt_d = cur_m_tens;
      mo_d = cur_m_ones;
      if (bcd_in_range(cur_h_ones, cur_h_tens, hour_max)) begin
        ht_d = cur_h_tens;
        ho_d = cur_h_ones;
      end else begin
        ht_d = 4'd0;
        ho_d = 4'd0;
      end
    end else if ((state_q == SET_HOUR) && inc_ev) begin
      {ht_d, ho_d} = bcd_inc(ho_q, ht_q, hour_max);
    end else if ((state_q == SET_MIN) && inc_ev) begin
      {mt_d, mo_d} = bcd_inc(mo_q, mt_q, MIN_MAX);
    end

    tmo_d = tmo_q;
    if (!in_set || any_ev) begin
      tmo_d = '0;
    end else if (tick_q) begin
      tmo_d = tmo_q + 1'b1;
    end

    // Phase restarts visible on field entry and on every edit
    blink_d = blink_q;
    phase_d = phase_q;
    if (!next_set || any_ev || (state_d != state_q)) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (tick_q) begin
      if (blink_q == BW'(BLINK_TICKS - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end

    load_d    = (state_d == COMMIT);
    setting_d = next_set;
    blank_d   = 4'b0000;
    if (phase_d) begin
      if (state_d == SET_HOUR)     blank_d = 4'b1100;
      else if (state_d == SET_MIN) blank_d = 4'b0011;
    end
  end

  assign set_h_tens = ht_q;
  assign set_h_ones = ho_q;
  assign set_m_tens = mt_q;
  assign set_m_ones = mo_q;
  assign load       = load_q;
  assign setting    = setting_q;
  assign blank      = blank_q;

endmodule
